lane_serializer: RTL and testbench

Captures a parallel snapshot of N lanes of WIDTH bits, each with a per-lane enable mask, and emits the enabled lanes one per beat over a valid/ready stream in ascending lane order. It drives the select line of the design's N-to-1 lane multiplexer from an internal pointer and streams out the selected word with its lane index. It sits between a parallel producer, such as a column or neuron array, and any single-word consumer.

---
 rtl/lane_serializer.sv | 110 +++++++++++
 tb/tb_lane_serializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// Snapshot-and-drain lane serializer: captures N lane words plus an enable mask and
// streams the enabled lanes out in ascending order over a valid/ready interface.
module lane_serializer #(
  parameter int N     = 16,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [N-1:0][WIDTH-1:0]   load_data,
  input  logic [N-1:0]              load_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N)-1:0]      out_index,
  output logic                      out_last,
  output logic                      done
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state_q, state_d;
  logic [N-1:0][WIDTH-1:0]  data_q;
  logic [N-1:0]             pend_q;
  logic [IW-1:0]            ptr_q;
  logic [IW-1:0]            hold_idx_q;
  logic [WIDTH-1:0]         hold_data_q;
  logic                     done_q;

  logic [N-1:0]             sel_oh;
  logic [N-1:0]             hi_pend;
  logic [WIDTH-1:0]         mux_data;
  logic                     load_fire;
  logic                     out_fire;

  function automatic logic [IW-1:0] lowest_bit(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Pending lanes strictly above the pointer; empty means the current beat is the last.
  assign sel_oh   = ONE << ptr_q;
  assign hi_pend  = pend_q & ~(sel_oh | (sel_oh - ONE));
  assign mux_data = data_q[ptr_q];

  assign load_fire = load_valid && (state_q == IDLE);
  assign out_fire  = out_ready  && (state_q == SCAN);
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = hold_data_q;
    out_index  = hold_idx_q;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid && (load_mask != '0)) state_d = SCAN;
      end
      SCAN: begin
        out_valid = 1'b1;
        out_last  = (hi_pend == '0);
        out_data  = mux_data;
        out_index = ptr_q;
        if (out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold registers keep out_data/out_index at the last emitted beat while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      pend_q      <= '0;
      ptr_q       <= '0;
      hold_data_q <= '0;
      hold_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (load_fire && (load_mask == '0)) || (out_fire && out_last);
      if (load_fire) begin
        data_q <= load_data;
        pend_q <= load_mask;
        ptr_q  <= lowest_bit(load_mask);
      end else if (out_fire) begin
        pend_q[ptr_q] <= 1'b0;
        hold_data_q   <= mux_data;
        hold_idx_q    <= ptr_q;
        if (!out_last) ptr_q <= lowest_bit(hi_pend);
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: inputs change and outputs are checked on the falling edge.
module tb_lane_serializer;

  localparam int N = 16;
  localparam int WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    load_valid;
  logic                    load_ready;
  logic [N-1:0][WIDTH-1:0] load_data;
  logic [N-1:0]            load_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [3:0]              out_index;
  logic                    out_last;
  logic                    done;

  int checks = 0;
  int failures = 0;

  lane_serializer #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_mask(load_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input int idx, input int dat, input bit last);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " index"}, 32'(out_index), 32'(idx));
    chk({tag, " data"},  32'(out_data),  32'(dat));
    chk({tag, " last"},  32'(out_last),  32'(last));
    chk({tag, " load_ready"}, 32'(load_ready), 32'd0);
    chk({tag, " done"},  32'(done), 32'd0);
  endtask

  task automatic idle_done(input string tag, input int idx, input int dat);
    chk({tag, " done"},  32'(done), 32'd1);
    chk({tag, " load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, " valid"}, 32'(out_valid), 32'd0);
    chk({tag, " last"},  32'(out_last), 32'd0);
    chk({tag, " hold index"}, 32'(out_index), 32'(idx));
    chk({tag, " hold data"},  32'(out_data),  32'(dat));
  endtask

  // Present a snapshot for one cycle; returns at the falling edge after the handshake edge.
  task automatic load(input logic [N-1:0] m, input int base, input int step);
    for (int i = 0; i < N; i++) load_data[i] = WIDTH'(base + i * step);
    load_mask  = m;
    load_valid = 1'b1;
    chk("load_ready before load", 32'(load_ready), 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_mask = '0;
    load_data = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst load_ready", 32'(load_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst out_index", 32'(out_index), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst load_ready", 32'(load_ready), 32'd1);

    // Full mask, data = 3*i
    load(16'hFFFF, 0, 3);
    for (int i = 0; i < 16; i++) begin
      beat("full", i, i * 3, i == 15);
      @(negedge clk);
    end
    idle_done("full end", 15, 45);
    @(negedge clk);
    chk("full done one-shot", 32'(done), 32'd0);

    // Sparse mask 8421, data = 0x10+i
    load(16'h8421, 8'h10, 1);
    beat("sparse0", 0, 8'h10, 1'b0);  @(negedge clk);
    beat("sparse5", 5, 8'h15, 1'b0);  @(negedge clk);
    beat("sparse10", 10, 8'h1A, 1'b0); @(negedge clk);
    beat("sparse15", 15, 8'h1F, 1'b1); @(negedge clk);
    idle_done("sparse end", 15, 8'h1F);
    @(negedge clk);

    // Zero mask: no beats, immediate done, outputs keep last values
    load(16'h0000, 8'h40, 1);
    idle_done("zero", 15, 8'h1F);
    @(negedge clk);
    chk("zero done one-shot", 32'(done), 32'd0);
    chk("zero no valid", 32'(out_valid), 32'd0);

    // Backpressure on lane 1
    out_ready = 1'b0;
    load(16'h0006, 8'hA0, 1);
    for (int k = 0; k < 3; k++) begin
      beat("bp stall", 1, 8'hA1, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    beat("bp accept", 1, 8'hA1, 1'b0); @(negedge clk);
    beat("bp lane2", 2, 8'hA2, 1'b1);  @(negedge clk);
    idle_done("bp end", 2, 8'hA2);
    @(negedge clk);

    // Back-to-back: load_valid held, second snapshot offered during SCAN
    for (int i = 0; i < N; i++) load_data[i] = WIDTH'(8'h50 + i);
    load_mask  = 16'h0003;
    load_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) load_data[i] = WIDTH'(8'h70 + i);
    load_mask = 16'h000C;
    beat("b2b A0", 0, 8'h50, 1'b0); @(negedge clk);
    beat("b2b A1", 1, 8'h51, 1'b1); @(negedge clk);
    idle_done("b2b A end", 1, 8'h51);
    @(negedge clk);
    load_valid = 1'b0;
    beat("b2b B2", 2, 8'h72, 1'b0); @(negedge clk);
    beat("b2b B3", 3, 8'h73, 1'b1); @(negedge clk);
    idle_done("b2b B end", 3, 8'h73);
    @(negedge clk);

    // Reset mid-scan at ptr 7
    load(16'hFFFF, 0, 3);
    for (int i = 0; i < 7; i++) begin
      beat("pre-rst", i, i * 3, 1'b0);
      @(negedge clk);
    end
    beat("pre-rst7", 7, 21, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst load_ready", 32'(load_ready), 32'd1);
    chk("midrst out_index", 32'(out_index), 32'd0);
    chk("midrst out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post-midrst valid", 32'(out_valid), 32'd0);
      chk("post-midrst done", 32'(done), 32'd0);
      chk("post-midrst load_ready", 32'(load_ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
